axi_wr_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI write master port (AW/W/B) among NUM_MASTERS counter write engines, so that several counter channels can target one interconnect slave port. It locks each grant for one complete transaction (address, burst data ending in wlast, and response), then releases it and rotates priority.

---
 rtl/axi_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master port (AW/W/B) among NUM_MASTERS
// write engines; each grant is held for one full address/data/response transaction.
module axi_wr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64
) (
  input  logic                                 clk,
  input  logic                                 areset,
  input  logic [NUM_MASTERS*4-1:0]             s_awid_i,
  input  logic [NUM_MASTERS*9-1:0]             s_awctl_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    s_awaddr_i,
  input  logic [NUM_MASTERS-1:0]               s_awvalid_i,
  output logic [NUM_MASTERS-1:0]               s_awready_o,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    s_wdata_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  s_wstrb_i,
  input  logic [NUM_MASTERS-1:0]               s_wlast_i,
  input  logic [NUM_MASTERS-1:0]               s_wvalid_i,
  output logic [NUM_MASTERS-1:0]               s_wready_o,
  output logic [NUM_MASTERS*2-1:0]             s_bresp_o,
  output logic [NUM_MASTERS-1:0]               s_bvalid_o,
  input  logic [NUM_MASTERS-1:0]               s_bready_i,
  output logic [3:0]                           m_awid_o,
  output logic [8:0]                           m_awctl_o,
  output logic [ADDR_WIDTH-1:0]                m_awaddr_o,
  output logic                                 m_awvalid_o,
  input  logic                                 m_awready_i,
  output logic [DATA_WIDTH-1:0]                m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]              m_wstrb_o,
  output logic                                 m_wlast_o,
  output logic                                 m_wvalid_o,
  input  logic                                 m_wready_i,
  input  logic [1:0]                           m_bresp_i,
  input  logic                                 m_bvalid_i,
  output logic                                 m_bready_o,
  output logic [NUM_MASTERS-1:0]               grant_o
);

  localparam int NM = NUM_MASTERS;
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t        state;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] scan_idx;
  logic          pick_valid;

  // First requester at or after the pointer, wrapping past NM-1 back to 0.
  always_comb begin
    int j;
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    j          = 0;
    for (int k = 0; k < NM; k++) begin
      j = int'(ptr) + k;
      if (j >= NM) j = j - NM;
      scan_idx = IW'(j);
      if (!pick_valid && s_awvalid_i[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_idx <= pick_idx;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_awvalid_o && m_awready_i) state <= DATA;
        end
        DATA: begin
          if (m_wvalid_o && m_wready_i && m_wlast_o) state <= RESP;
        end
        RESP: begin
          if (m_bvalid_i && m_bready_o) begin
            state <= IDLE;
            ptr   <= (grant_idx == IW'(NM - 1)) ? '0 : grant_idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel routing is purely combinational on the registered grant, gated by phase.
  always_comb begin
    int g;
    g           = int'(grant_idx);
    grant_o     = '0;
    s_awready_o = '0;
    s_wready_o  = '0;
    s_bvalid_o  = '0;
    s_bresp_o   = '0;
    m_awid_o    = '0;
    m_awctl_o   = '0;
    m_awaddr_o  = '0;
    m_awvalid_o = 1'b0;
    m_wdata_o   = '0;
    m_wstrb_o   = '0;
    m_wlast_o   = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    if (state != IDLE) grant_o[grant_idx] = 1'b1;
    case (state)
      ADDR: begin
        m_awid_o               = s_awid_i[g*4 +: 4];
        m_awctl_o              = s_awctl_i[g*9 +: 9];
        m_awaddr_o             = s_awaddr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        m_awvalid_o            = s_awvalid_i[grant_idx];
        s_awready_o[grant_idx] = m_awready_i;
      end
      DATA: begin
        m_wdata_o             = s_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb_o             = s_wstrb_i[g*SW +: SW];
        m_wlast_o             = s_wlast_i[grant_idx];
        m_wvalid_o            = s_wvalid_i[grant_idx];
        s_wready_o[grant_idx] = m_wready_i;
      end
      RESP: begin
        s_bvalid_o[grant_idx] = m_bvalid_i;
        s_bresp_o[g*2 +: 2]   = m_bresp_i;
        m_bready_o            = s_bready_i[grant_idx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with a transaction-phase reference model
// compared against every DUT output on each falling clock edge.
module tb_axi_wr_arbiter;

  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 64;
  localparam int SW = DW / 8;

  logic             clk = 1'b0;
  logic             areset;
  logic [NM*4-1:0]  s_awid;
  logic [NM*9-1:0]  s_awctl;
  logic [NM*AW-1:0] s_awaddr;
  logic [NM-1:0]    s_awvalid;
  logic [NM-1:0]    s_awready;
  logic [NM*DW-1:0] s_wdata;
  logic [NM*SW-1:0] s_wstrb;
  logic [NM-1:0]    s_wlast;
  logic [NM-1:0]    s_wvalid;
  logic [NM-1:0]    s_wready;
  logic [NM*2-1:0]  s_bresp;
  logic [NM-1:0]    s_bvalid;
  logic [NM-1:0]    s_bready;
  logic [3:0]       m_awid;
  logic [8:0]       m_awctl;
  logic [AW-1:0]    m_awaddr;
  logic             m_awvalid;
  logic             m_awready;
  logic [DW-1:0]    m_wdata;
  logic [SW-1:0]    m_wstrb;
  logic             m_wlast;
  logic             m_wvalid;
  logic             m_wready;
  logic [1:0]       m_bresp;
  logic             m_bvalid;
  logic             m_bready;
  logic [NM-1:0]    grant;

  int checks = 0;
  int errors = 0;

  axi_wr_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .areset(areset),
    .s_awid_i(s_awid), .s_awctl_i(s_awctl), .s_awaddr_i(s_awaddr),
    .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wlast_i(s_wlast),
    .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
    .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
    .m_awid_o(m_awid), .m_awctl_o(m_awctl), .m_awaddr_o(m_awaddr),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wlast_o(m_wlast),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
    .grant_o(grant)
  );

  initial forever #5 clk = ~clk;

  // Reference model: owner of the port, transaction phase (0 idle, 1 addr, 2 data, 3 resp),
  // rotating pointer, plus logs of grants and accepted beats per transaction.
  int mdl_owner = -1;
  int mdl_phase = 0;
  int mdl_ptr   = 0;
  int mdl_beats = 0;
  int grant_log[$];
  int beat_log[$];

  always @(posedge clk or negedge areset) begin
    if (!areset) begin
      mdl_owner = -1;
      mdl_phase = 0;
      mdl_ptr   = 0;
      mdl_beats = 0;
    end else begin
      case (mdl_phase)
        0: for (int k = 0; k < NM; k++)
             if (mdl_owner < 0 && s_awvalid[(mdl_ptr + k) % NM]) begin
               mdl_owner = (mdl_ptr + k) % NM;
               mdl_phase = 1;
               grant_log.push_back(mdl_owner);
             end
        1: if (s_awvalid[mdl_owner] && m_awready) mdl_phase = 2;
        2: if (s_wvalid[mdl_owner] && m_wready) begin
             mdl_beats++;
             if (s_wlast[mdl_owner]) begin
               beat_log.push_back(mdl_beats);
               mdl_beats = 0;
               mdl_phase = 3;
             end
           end
        3: if (m_bvalid && s_bready[mdl_owner]) begin
             mdl_ptr   = (mdl_owner + 1) % NM;
             mdl_owner = -1;
             mdl_phase = 0;
           end
        default: mdl_phase = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against what the model says it must be.
  always @(negedge clk) begin
    logic [NM-1:0]   e_grant, e_awready, e_wready, e_bvalid;
    logic [NM*2-1:0] e_bresp;
    logic [3:0]      e_awid;
    logic [8:0]      e_awctl;
    logic [AW-1:0]   e_awaddr;
    logic [DW-1:0]   e_wdata;
    logic [SW-1:0]   e_wstrb;
    logic            e_awvalid, e_wlast, e_wvalid, e_bready;
    e_grant = '0; e_awready = '0; e_wready = '0; e_bvalid = '0; e_bresp = '0;
    e_awid = '0; e_awctl = '0; e_awaddr = '0; e_wdata = '0; e_wstrb = '0;
    e_awvalid = 1'b0; e_wlast = 1'b0; e_wvalid = 1'b0; e_bready = 1'b0;
    if (mdl_owner >= 0) begin
      e_grant[mdl_owner] = 1'b1;
      if (mdl_phase == 1) begin
        e_awid               = s_awid[mdl_owner*4 +: 4];
        e_awctl              = s_awctl[mdl_owner*9 +: 9];
        e_awaddr             = s_awaddr[mdl_owner*AW +: AW];
        e_awvalid            = s_awvalid[mdl_owner];
        e_awready[mdl_owner] = m_awready;
      end
      if (mdl_phase == 2) begin
        e_wdata             = s_wdata[mdl_owner*DW +: DW];
        e_wstrb             = s_wstrb[mdl_owner*SW +: SW];
        e_wlast             = s_wlast[mdl_owner];
        e_wvalid            = s_wvalid[mdl_owner];
        e_wready[mdl_owner] = m_wready;
      end
      if (mdl_phase == 3) begin
        e_bvalid[mdl_owner]      = m_bvalid;
        e_bresp[mdl_owner*2 +: 2] = m_bresp;
        e_bready                 = s_bready[mdl_owner];
      end
    end
    checkOutput("cyc_grant",     64'(grant),     64'(e_grant));
    checkOutput("cyc_awvalid",   64'(m_awvalid), 64'(e_awvalid));
    checkOutput("cyc_awaddr",    m_awaddr,       e_awaddr);
    checkOutput("cyc_awid",      64'(m_awid),    64'(e_awid));
    checkOutput("cyc_awctl",     64'(m_awctl),   64'(e_awctl));
    checkOutput("cyc_s_awready", 64'(s_awready), 64'(e_awready));
    checkOutput("cyc_wvalid",    64'(m_wvalid),  64'(e_wvalid));
    checkOutput("cyc_wdata",     64'(m_wdata),   64'(e_wdata));
    checkOutput("cyc_wstrb",     64'(m_wstrb),   64'(e_wstrb));
    checkOutput("cyc_wlast",     64'(m_wlast),   64'(e_wlast));
    checkOutput("cyc_s_wready",  64'(s_wready),  64'(e_wready));
    checkOutput("cyc_s_bvalid",  64'(s_bvalid),  64'(e_bvalid));
    checkOutput("cyc_s_bresp",   64'(s_bresp),   64'(e_bresp));
    checkOutput("cyc_bready",    64'(m_bready),  64'(e_bready));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    s_awid = '0; s_awctl = '0; s_awaddr = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
  endtask

  task automatic applyStimulus(input int m, input logic [3:0] id, input logic [8:0] ctl,
                               input logic [AW-1:0] addr);
    s_awid[m*4 +: 4]    = id;
    s_awctl[m*9 +: 9]   = ctl;
    s_awaddr[m*AW +: AW] = addr;
    s_wstrb[m*SW +: SW] = '1;
    s_awvalid[m]        = 1'b1;
  endtask

  task automatic aw_phase(input int m, input int stall);
    int n = 0;
    while (!(mdl_phase == 1 && mdl_owner == m) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!(mdl_phase == 1 && mdl_owner == m)) begin
      errors++;
      $display("[TB] FAIL aw_grant_wait: owner %0d phase %0d, required owner %0d phase 1",
               mdl_owner, mdl_phase, m);
    end
    m_awready = 1'b0;
    repeat (stall) begin
      #1;
      checkOutput("aw_stall_valid", 64'(m_awvalid), 64'd1);
      checkOutput("aw_stall_addr", m_awaddr, s_awaddr[m*AW +: AW]);
      checkOutput("aw_stall_ready", 64'(s_awready), 64'd0);
      checkOutput("aw_stall_wready", 64'(s_wready), 64'd0);
      tick();
    end
    m_awready = 1'b1;
    #1;
    checkOutput("aw_route_addr", m_awaddr, s_awaddr[m*AW +: AW]);
    tick();
    s_awvalid[m] = 1'b0;
    m_awready    = 1'b0;
  endtask

  task automatic w_phase(input int m, input int beats, input logic [DW-1:0] base,
                         input bit toggle, input int stop_after);
    int acc = 0;
    int cyc = 0;
    s_wvalid[m] = 1'b1;
    while (acc < stop_after && cyc < 100) begin
      s_wdata[m*DW +: DW] = base + DW'(acc);
      s_wlast[m]          = (acc == beats - 1);
      m_wready            = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (m_wready) begin
        checkOutput("w_route_data", 64'(m_wdata), 64'(base + DW'(acc)));
        checkOutput("w_route_last", 64'(m_wlast), 64'(acc == beats - 1));
      end
      tick();
      if (m_wready) acc++;
      cyc++;
    end
    checkOutput("w_beats_sent", 64'(acc), 64'(stop_after));
    s_wvalid[m] = 1'b0;
    s_wlast[m]  = 1'b0;
    m_wready    = 1'b0;
  endtask

  task automatic b_phase(input int m, input logic [1:0] resp, input int delay,
                         input logic [NM*2-1:0] exp_bresp, input logic [NM-1:0] exp_bvalid);
    s_bready[m] = 1'b1;
    m_bvalid    = 1'b0;
    repeat (delay) begin
      #1;
      checkOutput("b_wait_bvalid", 64'(s_bvalid), 64'd0);
      tick();
    end
    m_bresp  = resp;
    m_bvalid = 1'b1;
    #1;
    checkOutput("b_route_resp", 64'(s_bresp), 64'(exp_bresp));
    checkOutput("b_route_valid", 64'(s_bvalid), 64'(exp_bvalid));
    tick();
    m_bvalid    = 1'b0;
    m_bresp     = '0;
    s_bready[m] = 1'b0;
    checkOutput("b_back_idle", 64'(grant), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    areset = 1'b0;
    clearInputs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_grant", 64'(grant), 64'd0);
    checkOutput("reset_awvalid", 64'(m_awvalid), 64'd0);
    areset = 1'b1;
    tick();

    // Single master 1, one beat.
    applyStimulus(1, 4'h3, {4'd0, 3'd2, 2'd1}, 64'h0000_0000_1000_0040);
    tick();
    checkOutput("t1_grant_latency", 64'(grant), 64'h2);
    aw_phase(1, 0);
    w_phase(1, 1, 32'h5, 1'b0, 1);
    b_phase(1, 2'b00, 0, 4'b0000, 2'b10);

    // Contention: both request together, master 0 re-requests during master 1.
    grant_log.delete();
    applyStimulus(0, 4'h1, {4'd0, 3'd2, 2'd1}, 64'h0000_0000_0000_0100);
    applyStimulus(1, 4'h2, {4'd0, 3'd2, 2'd1}, 64'h0000_0000_0000_0200);
    aw_phase(0, 0);
    w_phase(0, 1, 32'hA0, 1'b0, 1);
    b_phase(0, 2'b00, 0, 4'b0000, 2'b01);
    aw_phase(1, 0);
    applyStimulus(0, 4'h1, {4'd0, 3'd2, 2'd1}, 64'h0000_0000_0000_0300);
    w_phase(1, 1, 32'hB0, 1'b0, 1);
    b_phase(1, 2'b00, 0, 4'b0000, 2'b10);
    aw_phase(0, 0);
    w_phase(0, 1, 32'hC0, 1'b0, 1);
    b_phase(0, 2'b00, 0, 4'b0000, 2'b01);
    checkOutput("t2_grant_count", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() >= 3) begin
      checkOutput("t2_grant_0", 64'(grant_log[0]), 64'd0);
      checkOutput("t2_grant_1", 64'(grant_log[1]), 64'd1);
      checkOutput("t2_grant_2", 64'(grant_log[2]), 64'd0);
    end

    // Burst of four beats with toggling downstream wready.
    applyStimulus(0, 4'h4, {4'd3, 3'd2, 2'd1}, 64'h0000_0000_0000_1000);
    aw_phase(0, 0);
    w_phase(0, 4, 32'h10, 1'b1, 4);
    checkOutput("t3_beats", 64'(beat_log[$]), 64'd4);
    b_phase(0, 2'b00, 0, 4'b0000, 2'b01);

    // Backpressure on AW and B; master 1 offers W and BREADY without a grant.
    s_wvalid[1] = 1'b1;
    s_bready[1] = 1'b1;
    applyStimulus(0, 4'h5, {4'd0, 3'd2, 2'd1}, 64'h0000_0000_0000_2000);
    s_wvalid[0] = 1'b1;
    m_wready    = 1'b1;
    aw_phase(0, 5);
    w_phase(0, 1, 32'h55, 1'b0, 1);
    b_phase(0, 2'b00, 7, 4'b0000, 2'b01);
    s_wvalid[1] = 1'b0;
    s_bready[1] = 1'b0;

    // SLVERR forwarded only to the granted master.
    applyStimulus(0, 4'h6, {4'd0, 3'd2, 2'd1}, 64'h0000_0000_0000_3000);
    aw_phase(0, 0);
    w_phase(0, 1, 32'h66, 1'b0, 1);
    b_phase(0, 2'b10, 0, 4'b0010, 2'b01);

    // Reset in the middle of a burst, then re-arbitrate from pointer 0.
    applyStimulus(0, 4'h7, {4'd3, 3'd2, 2'd1}, 64'h0000_0000_0000_4000);
    aw_phase(0, 0);
    w_phase(0, 4, 32'h20, 1'b0, 2);
    s_wvalid[0] = 1'b1;
    m_wready    = 1'b1;
    #1;
    checkOutput("t6_mid_wvalid", 64'(m_wvalid), 64'd1);
    areset = 1'b0;
    #1;
    checkOutput("t6_rst_grant", 64'(grant), 64'd0);
    checkOutput("t6_rst_wvalid", 64'(m_wvalid), 64'd0);
    checkOutput("t6_rst_wready", 64'(s_wready), 64'd0);
    clearInputs();
    tick();
    areset = 1'b1;
    applyStimulus(0, 4'h8, {4'd0, 3'd2, 2'd1}, 64'h0000_0000_0000_5000);
    applyStimulus(1, 4'h9, {4'd0, 3'd2, 2'd1}, 64'h0000_0000_0000_6000);
    tick();
    checkOutput("t6_rearb_grant", 64'(grant), 64'h1);
    aw_phase(0, 0);
    w_phase(0, 1, 32'h77, 1'b0, 1);
    b_phase(0, 2'b00, 0, 4'b0000, 2'b01);
    aw_phase(1, 0);
    w_phase(1, 1, 32'h88, 1'b0, 1);
    b_phase(1, 2'b00, 0, 4'b0000, 2'b10);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
